filter_frame_writer: RTL and testbench
======================================

# filter_frame_writer

Sink for the 12-bit RGB444 pixel stream produced by the blurring/convolution filters. Accepts ready-qualified pixels in raster order, converts them to linear frame-buffer write addresses and writes them into one bank of a ping-pong (two-bank) frame RAM. Banks are swapped to the display side only on a vsync strobe after a complete frame, so the display never shows a partially written frame.

## Interface

Parameters:
- DATA_WIDTH, 12, pixel width (RGB444)
- ADDR_WIDTH, 17, per-bank word address width (covers 320x240 = 76800)
- MAX_WIDTH, 320, largest accepted image_width
- MAX_HEIGHT, 240, largest accepted image_height

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- ready_in  in  1  pixel valid; high for the whole frame, low between frames
- data_in  in  DATA_WIDTH  pixel, valid when ready_in=1
- image_height  in  9  frame rows, latched at frame start
- image_width  in  10  frame columns, latched at frame start
- display_vsync  in  1  one-cycle strobe from display side, swap opportunity
- wr_en  out  1  frame RAM write strobe
- wr_bank  out  1  bank written; always ~rd_bank
- wr_addr  out  ADDR_WIDTH  row*width+col within wr_bank
- wr_data  out  DATA_WIDTH  pixel to write
- rd_bank  out  1  bank the display reads
- frame_done  out  1  one-cycle pulse, frame fully written
- frame_error  out  1  sticky: overflow, short frame or bad size; cleared only by reset

## Operation

- FSM states: WAIT_LOW, IDLE, CAPTURE, DRAIN.
- WAIT_LOW: entered on reset; go to IDLE when ready_in=0. Guarantees no mid-frame join.
- IDLE: on ready_in=1, latch width/height, clear col/row/addr counters, clear frame_pending. If width or height is 0, or width>MAX_WIDTH, or height>MAX_HEIGHT: set frame_error, go to DRAIN, write nothing. Otherwise accept this first pixel (col 0, row 0) and go to CAPTURE.
- CAPTURE: each cycle with ready_in=1 accepts one pixel. col increments; at col=width-1 col wraps to 0 and row increments. addr increments by 1 per pixel (no multiplier).
- Last pixel (col=width-1, row=height-1) accepted: go to DRAIN, set frame_pending, pulse frame_done.
- ready_in falls in CAPTURE before the last pixel: short frame; set frame_error, go to IDLE, no frame_done, frame_pending stays 0.
- DRAIN: pixels arriving while ready_in=1 are dropped (no wr_en); if any arrive after a completed frame, set frame_error (overflow). Go to IDLE when ready_in=0.
- Bank swap: on any cycle with display_vsync=1 and (frame_pending=1 or frame_done=1), toggle rd_bank and clear frame_pending. wr_bank follows as ~rd_bank. Otherwise vsync is ignored.
- A new frame starting while frame_pending=1 clears frame_pending (old frame overwritten, never shown).
- Input sizes are ignored outside IDLE; changes mid-frame have no effect.

## Timing

- Reset values: wr_en=0, wr_addr=0, wr_data=0, rd_bank=0, wr_bank=1, frame_done=0, frame_error=0; state=WAIT_LOW; counters and frame_pending 0. Reset mid-frame aborts the frame and writes nothing more.
- Write latency 1 cycle: pixel accepted at edge n produces wr_en=1 with wr_addr/wr_data/wr_bank during cycle n+1.
- frame_done is high in the same cycle as the last pixel's wr_en.
- Back-to-back frames need at least one ready_in=0 cycle between them. Sustained throughput is 1 pixel/clock.
- Swap takes effect at the edge sampling display_vsync. rd_bank/wr_bank change in the following cycle. A vsync coincident with frame_done does swap.
- wr_bank must not change while a frame is in CAPTURE: a vsync in CAPTURE finds frame_pending=0 and is ignored.

## Test plan

- 4x3 frame, data 0x001..0x00C, ready_in high 12 cycles -> 12 writes to bank 1, addr 0..11, data matching; frame_done once with addr 11; frame_error=0.
- Then display_vsync pulse -> rd_bank=1, wr_bank=0. A second 4x3 frame writes bank 0. A vsync during capture leaves the banks unchanged.
- 4x3 frame with ready_in dropped after 7 pixels -> 7 writes (addr 0..6), no frame_done, frame_error=1. A later vsync does not swap.
- 4x3 frame with ready_in held 15 cycles -> 12 writes, frame_done, last 3 pixels dropped, frame_error=1.
- image_width=0 or 321 at frame start -> no writes, frame_error=1. A valid frame afterwards is written normally.
- ready_in already high at reset release -> no writes until ready_in low then high. Reset asserted at pixel 5 -> all outputs return to reset values next cycle.

Source files
------------

// File: rtl/filter_frame_writer.sv
// Ping-pong frame-buffer writer for the RGB444 filter output stream.
// Pixels arrive in raster order; banks flip only on vsync after a complete frame.
module filter_frame_writer #(
   parameter int DATA_WIDTH = 12,
   parameter int ADDR_WIDTH = 17,
   parameter int MAX_WIDTH  = 320,
   parameter int MAX_HEIGHT = 240
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ready_in,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic [8:0]            image_height,
   input  logic [9:0]            image_width,
   input  logic                  display_vsync,
   output logic                  wr_en,
   output logic                  wr_bank,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [DATA_WIDTH-1:0] wr_data,
   output logic                  rd_bank,
   output logic                  frame_done,
   output logic                  frame_error
);

   typedef enum logic [1:0] {WAIT_LOW, IDLE, CAPTURE, DRAIN} state_t;

   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

   state_t                state_q, state_d;
   logic [9:0]            col_q, col_d, width_q, width_d;
   logic [8:0]            row_q, row_d, height_q, height_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d, wr_addr_q, wr_addr_d;
   logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
   logic                  pending_q, pending_d;
   logic                  rd_bank_q, rd_bank_d;
   logic                  wr_en_q, wr_en_d;
   logic                  done_q, done_d;
   logic                  error_q, error_d;

   logic [9:0]            col_cur, w_cur;
   logic [8:0]            row_cur, h_cur;
   logic [ADDR_WIDTH-1:0] addr_cur;
   logic                  accept, size_bad, last_col, last_pix;

   always_comb begin
      state_d   = state_q;
      col_d     = col_q;
      row_d     = row_q;
      addr_d    = addr_q;
      width_d   = width_q;
      height_d  = height_q;
      pending_d = pending_q;
      rd_bank_d = rd_bank_q;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      error_d   = error_q;
      wr_en_d   = 1'b0;
      done_d    = 1'b0;
      accept    = 1'b0;

      // In IDLE the first pixel uses the live size inputs and zeroed counters
      col_cur  = (state_q == IDLE) ? 10'd0 : col_q;
      row_cur  = (state_q == IDLE) ? 9'd0 : row_q;
      addr_cur = (state_q == IDLE) ? '0 : addr_q;
      w_cur    = (state_q == IDLE) ? image_width : width_q;
      h_cur    = (state_q == IDLE) ? image_height : height_q;
      last_col = (col_cur == w_cur - 10'd1);
      last_pix = last_col && (row_cur == h_cur - 9'd1);
      size_bad = (image_width == 10'd0) || (image_height == 9'd0) ||
                 (image_width > 10'(MAX_WIDTH)) || (image_height > 9'(MAX_HEIGHT));

      if (display_vsync && (pending_q || done_q)) begin
         rd_bank_d = ~rd_bank_q;
         pending_d = 1'b0;
      end

      case (state_q)
         WAIT_LOW: if (!ready_in) state_d = IDLE;
         IDLE: begin
            if (ready_in) begin
               width_d   = image_width;
               height_d  = image_height;
               col_d     = '0;
               row_d     = '0;
               addr_d    = '0;
               pending_d = 1'b0;
               if (size_bad) begin
                  error_d = 1'b1;
                  state_d = DRAIN;
               end else begin
                  accept  = 1'b1;
                  state_d = CAPTURE;
               end
            end
         end
         CAPTURE: begin
            if (ready_in) begin
               accept = 1'b1;
            end else begin
               error_d = 1'b1;
               state_d = IDLE;
            end
         end
         DRAIN: begin
            if (ready_in) error_d = 1'b1;
            else          state_d = IDLE;
         end
         default: state_d = WAIT_LOW;
      endcase

      if (accept) begin
         wr_en_d   = 1'b1;
         wr_addr_d = addr_cur;
         wr_data_d = data_in;
         addr_d    = addr_cur + ADDR_ONE;
         if (last_col) begin
            col_d = '0;
            row_d = row_cur + 9'd1;
         end else begin
            col_d = col_cur + 10'd1;
            row_d = row_cur;
         end
         if (last_pix) begin
            state_d   = DRAIN;
            pending_d = 1'b1;
            done_d    = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= WAIT_LOW;
         col_q     <= '0;
         row_q     <= '0;
         addr_q    <= '0;
         width_q   <= '0;
         height_q  <= '0;
         pending_q <= 1'b0;
         rd_bank_q <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         wr_en_q   <= 1'b0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         col_q     <= col_d;
         row_q     <= row_d;
         addr_q    <= addr_d;
         width_q   <= width_d;
         height_q  <= height_d;
         pending_q <= pending_d;
         rd_bank_q <= rd_bank_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         wr_en_q   <= wr_en_d;
         done_q    <= done_d;
         error_q   <= error_d;
      end
   end

   assign wr_en       = wr_en_q;
   assign wr_addr     = wr_addr_q;
   assign wr_data     = wr_data_q;
   assign rd_bank     = rd_bank_q;
   assign wr_bank     = ~rd_bank_q;
   assign frame_done  = done_q;
   assign frame_error = error_q;

endmodule

// File: tb/tb_filter_frame_writer.sv
// Directed bench for filter_frame_writer: logs RAM writes on the falling edge
// and compares them against hand-computed frame contents and bank states.
module tb_filter_frame_writer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ready_in = 1'b0;
   logic [11:0] data_in = '0;
   logic [8:0]  image_height = '0;
   logic [9:0]  image_width = '0;
   logic        display_vsync = 1'b0;
   logic        wr_en, wr_bank, rd_bank, frame_done, frame_error;
   logic [16:0] wr_addr;
   logic [11:0] wr_data;

   int n_cmp = 0;
   int n_err = 0;

   int wa_q[$];
   int wd_q[$];
   int wb_q[$];
   int done_cnt = 0;
   int done_addr = -1;

   filter_frame_writer dut (
      .clk          (clk),
      .reset        (reset),
      .ready_in     (ready_in),
      .data_in      (data_in),
      .image_height (image_height),
      .image_width  (image_width),
      .display_vsync(display_vsync),
      .wr_en        (wr_en),
      .wr_bank      (wr_bank),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .rd_bank      (rd_bank),
      .frame_done   (frame_done),
      .frame_error  (frame_error)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (wr_en) begin
         wa_q.push_back(int'(wr_addr));
         wd_q.push_back(int'(wr_data));
         wb_q.push_back(int'(wr_bank));
      end
      if (frame_done) begin
         done_cnt  = done_cnt + 1;
         done_addr = int'(wr_addr);
      end
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic clear_log();
      wa_q.delete();
      wd_q.delete();
      wb_q.delete();
      done_cnt  = 0;
      done_addr = -1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      ready_in = 1'b0;
      display_vsync = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic vsync_pulse();
      display_vsync = 1'b1;
      @(negedge clk);
      display_vsync = 1'b0;
      @(negedge clk);
   endtask

   // Drive n consecutive pixels base, base+1, ...; vsync strobed on pixel vs_at
   task automatic frame(input int w, input int h, input int n, input int base, input int vs_at);
      clear_log();
      image_width  = 10'(w);
      image_height = 9'(h);
      for (int i = 0; i < n; i++) begin
         ready_in      = 1'b1;
         data_in       = 12'(base + i);
         display_vsync = (i == vs_at);
         @(negedge clk);
      end
      ready_in      = 1'b0;
      display_vsync = 1'b0;
      data_in       = '0;
      repeat (3) @(negedge clk);
   endtask

   task automatic check_frame(input string tag, input int n, input int bank, input int base,
                              input int ndone, input int err);
      chk({tag, ".nwr"}, wa_q.size(), n);
      for (int i = 0; i < n && i < wa_q.size(); i++) begin
         chk({tag, ".addr"}, wa_q[i], i);
         chk({tag, ".data"}, wd_q[i], (base + i) & 12'hFFF);
         chk({tag, ".bank"}, wb_q[i], bank);
      end
      chk({tag, ".ndone"}, done_cnt, ndone);
      if (ndone > 0) chk({tag, ".done_addr"}, done_addr, n - 1);
      chk({tag, ".err"}, int'(frame_error), err);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, ".wr_en"}, int'(wr_en), 0);
      chk({tag, ".wr_addr"}, int'(wr_addr), 0);
      chk({tag, ".wr_data"}, int'(wr_data), 0);
      chk({tag, ".rd_bank"}, int'(rd_bank), 0);
      chk({tag, ".wr_bank"}, int'(wr_bank), 1);
      chk({tag, ".done"}, int'(frame_done), 0);
      chk({tag, ".err"}, int'(frame_error), 0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_reset_outputs("rst");
      reset = 1'b0;
      @(negedge clk);
      check_reset_outputs("rst_rel");

      // Complete 4x3 frame into bank 1, then publish it
      frame(4, 3, 12, 1, -1);
      check_frame("fa", 12, 1, 1, 1, 0);
      vsync_pulse();
      chk("swap1.rd", int'(rd_bank), 1);
      chk("swap1.wr", int'(wr_bank), 0);

      // Second frame into bank 0; vsync during capture is ignored
      frame(4, 3, 12, 'h100, 5);
      check_frame("fb", 12, 0, 'h100, 1, 0);
      chk("cap_vs.rd", int'(rd_bank), 1);

      // Short frame discards the pending frame; later vsync must not swap
      frame(4, 3, 7, 'h200, -1);
      check_frame("short", 7, 0, 'h200, 0, 1);
      vsync_pulse();
      chk("short_vs.rd", int'(rd_bank), 1);

      // Overflow, with vsync coinciding with frame_done
      do_reset();
      chk("rst2.err", int'(frame_error), 0);
      chk("rst2.rd", int'(rd_bank), 0);
      frame(4, 3, 15, 'h300, 12);
      check_frame("ovf", 12, 1, 'h300, 1, 1);
      chk("ovf_vs.rd", int'(rd_bank), 1);

      // Illegal sizes write nothing; later legal frames still write
      do_reset();
      frame(0, 3, 12, 'h700, -1);
      check_frame("w0", 0, 1, 0, 0, 1);
      do_reset();
      frame(321, 3, 12, 'h700, -1);
      check_frame("w321", 0, 1, 0, 0, 1);
      frame(2, 2, 4, 'h400, -1);
      check_frame("after_bad", 4, 1, 'h400, 1, 1);
      frame(320, 1, 320, 'h500, -1);
      check_frame("wmax", 320, 1, 'h500, 1, 1);

      // ready_in already high at reset release: no mid-frame join
      clear_log();
      reset = 1'b1;
      ready_in = 1'b1;
      data_in = 12'h0AA;
      image_width = 10'd4;
      image_height = 9'd3;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (6) @(negedge clk);
      chk("join.nwr", wa_q.size(), 0);
      ready_in = 1'b0;
      @(negedge clk);
      frame(4, 3, 12, 'h600, -1);
      check_frame("join_fr", 12, 1, 'h600, 1, 0);
      vsync_pulse();
      chk("swap3.rd", int'(rd_bank), 1);

      // Reset asserted mid-frame after pixel 5
      image_width = 10'd4;
      image_height = 9'd3;
      for (int i = 0; i < 5; i++) begin
         ready_in = 1'b1;
         data_in  = 12'(12'h800 + i);
         @(negedge clk);
      end
      chk("mid.wr_en", int'(wr_en), 1);
      chk("mid.addr", int'(wr_addr), 4);
      reset = 1'b1;
      @(negedge clk);
      check_reset_outputs("midrst");
      clear_log();
      reset = 1'b0;
      ready_in = 1'b0;
      repeat (4) @(negedge clk);
      chk("midrst.nwr", wa_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
